alu_req_arbiter: RTL and testbench

//   Clocked round-robin arbiter/sequencer that shares one alu_top instance between NUM_REQ requesters.

---
 rtl/alu_req_arbiter_if.sv | 29 ++
 rtl/alu_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Requester-side bundle for alu_req_arbiter: packed per-requester request fields and the shared
// response channel. Requester i occupies bit i and slice [i*W +: W] of every packed field.
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 8
);
  // Handshake: a requester raises req_valid[i] and holds its operands stable until it sees the
  // one-cycle req_ready[i] pulse; the transfer happens in that cycle. resp_valid[i] is a one-cycle
  // pulse with no backpressure, and resp_result/resp_error are meaningful only while it is high.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_opa;
  logic [NUM_REQ*DATA_W-1:0] req_opb;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_error;

  modport master (
    output req_valid, req_opa, req_opb, req_op,
    input  req_ready, resp_valid, resp_result, resp_error
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_op,
    output req_ready, resp_valid, resp_result, resp_error
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin sequencer sharing one untimed ALU between NUM_REQ requesters.
// Optional macro ALU_OPCODE_CHECK_EN: operators above 8'h03 are answered with an error, bypassing the ALU.
module alu_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_req_arbiter_if.slave    bus,
  output logic                busy,
  output logic [DATA_W-1:0]   alu_operand_a,
  output logic [DATA_W-1:0]   alu_operand_b,
  output logic [OP_W-1:0]     alu_operator,
  output logic                alu_op_valid,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [2:0]          dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;

  logic                pick_vld;
  logic [PTR_W-1:0]    pick;
  logic                illegal;
  logic [NUM_REQ-1:0]  ready_vec;
  logic [NUM_REQ-1:0]  resp_vec;

  // First pending requester at or above ptr, wrapping modulo NUM_REQ. Returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && vld[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    {pick_vld, pick} = rr_pick(bus.req_valid, ptr_q);
  end

`ifdef ALU_OPCODE_CHECK_EN
  logic [OP_W-1:0] pick_op;
  always_comb begin
    pick_op = bus.req_op[pick*OP_W +: OP_W];
    illegal = (pick_op > OP_W'(3));
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d = pick;
          ptr_d = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          if (illegal) begin
            // Rejected operator: ALU outputs keep their previous values.
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            opa_d   = bus.req_opa[pick*DATA_W +: DATA_W];
            opb_d   = bus.req_opb[pick*DATA_W +: DATA_W];
            op_d    = bus.req_op[pick*OP_W +: OP_W];
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_FIRE;
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          // Result is sampled on the edge that enters RESP so it is stable for the whole pulse.
          res_d   = alu_result;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // req_ready is a combinational grant; rst_n keeps it quiet while the block is held in reset.
  always_comb begin
    ready_vec = '0;
    resp_vec  = '0;
    if (state_q == S_IDLE && pick_vld && rst_n) ready_vec[pick] = 1'b1;
    if (state_q == S_RESP) resp_vec[gnt_q] = 1'b1;
  end

  assign bus.req_ready   = ready_vec;
  assign bus.resp_valid  = resp_vec;
  assign bus.resp_result = res_q;
  assign bus.resp_error  = err_q;

  assign busy          = (state_q != S_IDLE);
  assign alu_op_valid  = (state_q == S_FIRE);
  assign alu_operand_a = opa_q;
  assign alu_operand_b = opb_q;
  assign alu_operator  = op_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a small behavioural ALU; responses are scored against
// an expected queue of {error, requester one-hot, result}.
module tb_alu_req_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int DATA_W      = 32;
  localparam int OP_W        = 8;
  localparam int WAIT_CYCLES = 2;
  localparam int LAT         = 3 + WAIT_CYCLES;
  localparam int SB_W        = 1 + NUM_REQ + DATA_W;

`ifdef ALU_OPCODE_CHECK_EN
  localparam int              ILL_LAT = 1;
  localparam int              ILL_OPV = 0;
  localparam logic            ILL_ERR = 1'b1;
  localparam logic [31:0]     ILL_RES = 32'h0000_0000;
  localparam logic [31:0]     ILL_OPA = 32'hFFFF_0000;
`else
  localparam int              ILL_LAT = LAT;
  localparam int              ILL_OPV = 1;
  localparam logic            ILL_ERR = 1'b0;
  localparam logic [31:0]     ILL_RES = 32'hDEAD_BEEF;
  localparam logic [31:0]     ILL_OPA = 32'h0000_0003;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              busy;
  logic [DATA_W-1:0] alu_operand_a, alu_operand_b, alu_result;
  logic [OP_W-1:0]   alu_operator;
  logic              alu_op_valid;
  logic [2:0]        dbg_state;

  alu_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_req_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_operator  (alu_operator),
    .alu_op_valid  (alu_op_valid),
    .alu_result    (alu_result),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  always_comb begin
    case (alu_operator)
      8'h00:   alu_result = alu_operand_a + alu_operand_b;
      8'h01:   alu_result = alu_operand_a - alu_operand_b;
      8'h02:   alu_result = alu_operand_a & alu_operand_b;
      8'h03:   alu_result = alu_operand_a | alu_operand_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [SB_W-1:0] sb_pack(input logic err, input logic [NUM_REQ-1:0] id1h,
                                              input logic [DATA_W-1:0] res);
    return {err, id1h, res};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [SB_W-1:0] exp_q[$];
  int              opv_cnt = 0, last_opv = 0, resp_cnt = 0, last_resp = 0;
  int              overlap_cnt = 0, multi_cnt = 0;
  logic [31:0]     last_opv_a = '0, last_opv_b = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_op_valid) begin
        opv_cnt++;
        last_opv   = cyc;
        last_opv_a = alu_operand_a;
        last_opv_b = alu_operand_b;
      end
      if (bus.req_ready != 0 && bus.resp_valid != 0) overlap_cnt++;
      if ($countones(bus.req_ready) > 1) multi_cnt++;
      if (bus.resp_valid != 0) begin
        resp_cnt++;
        last_resp = cyc;
        if (exp_q.size() == 0) check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        else check("resp", 64'(sb_pack(bus.resp_error, bus.resp_valid, bus.resp_result)),
                   64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] op);
    bus.req_opa[idx*DATA_W +: DATA_W] = a;
    bus.req_opb[idx*DATA_W +: DATA_W] = b;
    bus.req_op[idx*OP_W +: OP_W]      = op;
    bus.req_valid[idx]                = 1'b1;
  endtask

  // Returns the accept cycle; leaves the caller at posedge+1 of the following cycle.
  task automatic wait_accept(input int idx, output int t);
    t = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("accept_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (resp_cnt < target) check("resp_timeout", 64'(resp_cnt), 64'(target));
    tick();
  endtask

  // ---------------- stimulus ----------------
  int cont_id[4] = '{0, 1, 0, 1};

  initial begin
    int t, r0, opv0, got, low, n_acc;
    int done[NUM_REQ];
    int acc_t[3];

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.req_op    = '0;
    repeat (3) tick();
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_state",    64'(dbg_state), 64'd0);
    check("rst_opv",      64'(alu_op_valid), 64'd0);
    check("rst_opa",      64'(alu_operand_a), 64'd0);
    check("rst_resp_vld", 64'(bus.resp_valid), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single add on requester 0.
    exp_q.push_back(sb_pack(1'b0, 2'b01, 32'd12));
    opv0 = opv_cnt;
    r0   = resp_cnt;
    drive_req(0, 32'd5, 32'd7, 8'h00);
    wait_accept(0, t);
    bus.req_valid[0] = 1'b0;
    wait_resp(r0 + 1);
    check("add_latency",   64'(last_resp - t), 64'(LAT));
    check("add_opv_count", 64'(opv_cnt - opv0), 64'd1);
    check("add_opv_cycle", 64'(last_opv - t), 64'd2);
    check("add_fire_opa",  64'(last_opv_a), 64'd5);
    check("add_fire_opb",  64'(last_opv_b), 64'd7);
    check("add_idle_busy", 64'(busy), 64'd0);

    // Reset while the operation sits in WAIT: nothing must come back.
    r0 = resp_cnt;
    drive_req(0, 32'd9, 32'd9, 8'h00);
    wait_accept(0, t);
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    check("mid_state_wait", 64'(dbg_state), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",     64'(busy), 64'd0);
    check("mid_rst_state",    64'(dbg_state), 64'd0);
    check("mid_rst_opa",      64'(alu_operand_a), 64'd0);
    check("mid_rst_result",   64'(bus.resp_result), 64'd0);
    check("mid_rst_error",    64'(bus.resp_error), 64'd0);
    check("mid_rst_resp_vld", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_ready",    64'(bus.req_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("mid_rst_no_resp", 64'(resp_cnt - r0), 64'd0);

    // Subtract wrap on requester 1.
    exp_q.push_back(sb_pack(1'b0, 2'b10, 32'hFFFF_FFFF));
    r0 = resp_cnt;
    drive_req(1, 32'd0, 32'd1, 8'h01);
    wait_accept(1, t);
    bus.req_valid[1] = 1'b0;
    wait_resp(r0 + 1);
    check("sub_latency", 64'(last_resp - t), 64'(LAT));

    // Contention: both requesters hold valid for two ops each.
    exp_q.push_back(sb_pack(1'b0, 2'b01, 32'hF000_F000));
    exp_q.push_back(sb_pack(1'b0, 2'b10, 32'h1234_5678));
    exp_q.push_back(sb_pack(1'b0, 2'b01, 32'h0000_00FF));
    exp_q.push_back(sb_pack(1'b0, 2'b10, 32'h0F0F_0000));
    r0      = resp_cnt;
    done[0] = 0;
    done[1] = 0;
    drive_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 8'h02);
    drive_req(1, 32'h1234_0000, 32'h0000_5678, 8'h03);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (bus.req_ready != 0) begin
          got = bus.req_ready[1] ? 1 : 0;
          break;
        end
      end
      check("cont_grant", 64'(got), 64'(cont_id[k]));
      tick();
      if (got >= 0) begin
        done[got]++;
        if (done[got] == 1 && got == 0)      drive_req(0, 32'h0000_00F0, 32'h0000_000F, 8'h03);
        else if (done[got] == 1 && got == 1) drive_req(1, 32'hFFFF_0000, 32'h0F0F_0F0F, 8'h02);
        else bus.req_valid[got] = 1'b0;
      end
    end
    bus.req_valid = '0;
    wait_resp(r0 + 4);

    // Illegal operator on requester 0.
    exp_q.push_back(sb_pack(ILL_ERR, 2'b01, ILL_RES));
    r0   = resp_cnt;
    opv0 = opv_cnt;
    drive_req(0, 32'd3, 32'd4, 8'h10);
    wait_accept(0, t);
    bus.req_valid[0] = 1'b0;
    wait_resp(r0 + 1);
    check("ill_latency",  64'(last_resp - t), 64'(ILL_LAT));
    check("ill_opv_count", 64'(opv_cnt - opv0), 64'(ILL_OPV));
    check("ill_alu_opa",  64'(alu_operand_a), 64'(ILL_OPA));

    // Back-to-back: requester 0 valid continuously for three ops.
    for (int k = 0; k < 3; k++) exp_q.push_back(sb_pack(1'b0, 2'b01, 32'd30));
    r0    = resp_cnt;
    n_acc = 0;
    low   = 0;
    drive_req(0, 32'd10, 32'd20, 8'h00);
    for (int c = 0; c < 80 && n_acc < 3; c++) begin
      @(negedge clk);
      if (n_acc > 0 && !busy) low++;
      if (bus.req_ready[0]) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    tick();
    bus.req_valid[0] = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd3);
    if (n_acc == 3) begin
      check("b2b_gap_1", 64'(acc_t[1] - acc_t[0]), 64'(4 + WAIT_CYCLES));
      check("b2b_gap_2", 64'(acc_t[2] - acc_t[1]), 64'(4 + WAIT_CYCLES));
    end
    check("b2b_busy_low", 64'(low), 64'd2);
    wait_resp(r0 + 3);

    repeat (4) tick();
    check("no_ready_resp_overlap", 64'(overlap_cnt), 64'd0);
    check("ready_onehot",          64'(multi_cnt), 64'd0);
    check("exp_q_drained",         64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
